// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-code constants, the
// controller state encoding and the multiply step-counter width helper.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_MUL  = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } alu_state_t;

    // Width of the multiply step counter; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath for the seven single-cycle ops. MUL is not handled
// here and yields y = 0, ovf = 0; the sequencer owns the multiplier.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       f,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_add;
    logic             ovf_sub;
    logic             lt;

    assign sum  = a + b;
    assign diff = a - b;

    assign ovf_add = (a[MSB] == b[MSB]) && (sum[MSB]  != a[MSB]);
    assign ovf_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

    // Sign of the difference is wrong exactly when the subtraction
    // overflowed, so flipping it by the overflow gives the true compare.
    assign lt = diff[MSB] ^ ovf_sub;

    // Op select; ovf is only meaningful for ADD and SUB.
    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (f)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD: begin
                y   = sum;
                ovf = ovf_add;
            end
            ALU_ANDN: y = a & ~b;
            ALU_ORN:  y = a | ~b;
            ALU_SUB: begin
                y   = diff;
                ovf = ovf_sub;
            end
            ALU_SLT:  y = {{(WIDTH-1){1'b0}}, lt};
            default: begin
                y   = '0;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides.
// Build option: ALU_MUL_EN compiles in the shift-add multiplier (BUSY state,
// step counter, operand shifters). Without it, f=011 completes in one cycle
// with y = 0, zero = 1, ovf = 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no result held, ready for a new operation
// BUSY  | shift-add multiply in progress, input stalled
// DONE  | result held on y/zero/ovf, waiting for the consumer
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       f,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ovf
);

    alu_state_t state;
    alu_state_t state_nxt;

    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] core_y;
    logic             core_ovf;

    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             ovf_q;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .f   (f),
        .a   (a),
        .b   (b),
        .y   (core_y),
        .ovf (core_ovf)
    );

    assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic             mul_last;

    assign is_mul   = (f == ALU_MUL);
    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));
`else
    assign is_mul = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; in_ready never depends on in_valid.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = is_mul ? BUSY : DONE;
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (mul_last) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_nxt = is_mul ? BUSY : DONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) begin
            in_ready = 1'b0;
        end
    end

`ifdef ALU_MUL_EN
    // Shift-add multiplier: one partial product per cycle while BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && is_mul) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end
`endif

    // Result registers: loaded at accept for single-cycle ops and on the
    // last multiply step; otherwise held so a stalled consumer sees no change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q    <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept && !is_mul) begin
            y_q    <= core_y;
            zero_q <= (core_y == '0);
            ovf_q  <= core_ovf;
        end
`ifdef ALU_MUL_EN
        else if ((state == BUSY) && mul_last) begin
            y_q    <= acc_nxt;
            zero_q <= (acc_nxt == '0);
            ovf_q  <= 1'b0;
        end
`endif
    end

    assign y    = y_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32. Covers both builds of ALU_MUL_EN.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        zero;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f         (f),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op, wait (bounded) for acceptance, then drop in_valid.
    task automatic issue(input logic [2:0] fi, input logic [31:0] ai, input logic [31:0] bi);
        int w;
        in_valid = 1'b1;
        f = fi;
        a = ai;
        b = bi;
        #1;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) check("issue_timeout", 64'd0, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [2:0] fi, input logic [31:0] ai,
                        input logic [31:0] bi, input logic [31:0] ey, input logic ez,
                        input logic eo);
        issue(fi, ai, bi);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_y"}, {32'd0, y}, {32'd0, ey});
        check({tag, "_zero"}, {63'd0, zero}, {63'd0, ez});
        check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
    endtask

`ifdef ALU_MUL_EN
    // Accept a MUL and count cycles (accept edge included) until out_valid.
    task automatic mul_run(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                           input logic [31:0] ey, input logic ez, input int elat);
        int n;
        in_valid = 1'b1;
        f = 3'b011;
        a = ai;
        b = bi;
        #1;
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        n = 1;
        check({tag, "_busy_in_ready"}, {63'd0, in_ready}, 64'd0);
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(elat));
        check({tag, "_y"}, {32'd0, y}, {32'd0, ey});
        check({tag, "_zero"}, {63'd0, zero}, {63'd0, ez});
        check({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        f         = 3'b010;
        a         = 32'd1;
        b         = 32'd1;

        // Reset with in_valid held high.
        step();
        step();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_y", {32'd0, y}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);
        check("rel_out_valid", {63'd0, out_valid}, 64'd0);

        // Single-cycle ops and overflow boundaries.
        run1("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        run1("sub_zero", 3'b110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        run1("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 1'b0, 1'b0);
        run1("slt_ge", 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        run1("sub_ovf", 3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run1("slt_ovf", 3'b111, 32'h8000_0000, 32'h0000_0001, 32'd1, 1'b0, 1'b0);
        run1("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1'b1, 1'b0);
        run1("andn", 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h00F0_00F0, 1'b0, 1'b0);
        run1("orn", 3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0FF_F0FF, 1'b0, 1'b0);
        step();
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);

        // Back-to-back AND, OR, ADD, SUB.
        in_valid = 1'b1;
        f = 3'b000; a = 32'hFF00_FF00; b = 32'h0F0F_0F0F;
        step();
        check("b2b_and_v", {63'd0, out_valid}, 64'd1);
        check("b2b_and_y", {32'd0, y}, 64'h0F00_0F00);
        check("b2b_and_rdy", {63'd0, in_ready}, 64'd1);
        f = 3'b001; a = 32'h0000_00F0; b = 32'h0000_000F;
        step();
        check("b2b_or_v", {63'd0, out_valid}, 64'd1);
        check("b2b_or_y", {32'd0, y}, 64'h0000_00FF);
        f = 3'b010; a = 32'd1; b = 32'd2;
        step();
        check("b2b_add_v", {63'd0, out_valid}, 64'd1);
        check("b2b_add_y", {32'd0, y}, 64'd3);
        f = 3'b110; a = 32'd10; b = 32'd3;
        step();
        check("b2b_sub_v", {63'd0, out_valid}, 64'd1);
        check("b2b_sub_y", {32'd0, y}, 64'd7);
        in_valid = 1'b0;
        step();
        check("b2b_drain", {63'd0, out_valid}, 64'd0);

        // Backpressure with an OR result pending.
        out_ready = 1'b0;
        in_valid = 1'b1;
        f = 3'b001; a = 32'h1234_0000; b = 32'h0000_5678;
        step();
        f = 3'b010; a = 32'd1; b = 32'd1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_y", {32'd0, y}, 64'h1234_5678);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_next_v", {63'd0, out_valid}, 64'd1);
        check("bp_next_y", {32'd0, y}, 64'd2);
        step();
        check("bp_drain", {63'd0, out_valid}, 64'd0);

`ifdef ALU_MUL_EN
        mul_run("mul_ffff", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 33);
        mul_run("mul_wrap", 32'h8000_0000, 32'h0000_0002, 32'd0, 1'b1, 33);
        mul_run("mul_small", 32'd7, 32'd6, 32'd42, 1'b0, 33);
        step();

        // Reset in the middle of a multiply.
        in_valid = 1'b1;
        f = 3'b011; a = 32'd3; b = 32'd5;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("mulrst_no_valid", 64'(seen), 64'd0);
        check("mulrst_idle_rdy", {63'd0, in_ready}, 64'd1);
        check("mulrst_y", {32'd0, y}, 64'd0);
`else
        run1("mul_off", 3'b011, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0);
        step();

        // Reset while a result is held.
        out_ready = 1'b0;
        issue(3'b001, 32'h0000_0F00, 32'h0000_00F0);
        check("donerst_pre_v", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("donerst_no_valid", 64'(seen), 64'd0);
        check("donerst_y", {32'd0, y}, 64'd0);
        check("donerst_rdy", {63'd0, in_ready}, 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
